// File: rtl/uart_core.sv
// UART with a shared 16x oversampling tick generator, an independent TX and RX, and LSB-first 8N1 framing.
// Define UART_PARITY_EN to add an even-parity bit before the stop bit and the o_rx_parity_err port.
module uart_core #(
  parameter int NB_DATA          = 8,
  parameter int NCYCLES_PER_TICK = 163
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_tx_data,
  input  logic               i_tx_start,
  output logic               o_tx,
  output logic               o_tx_done,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_done,
`ifdef UART_PARITY_EN
  output logic               o_rx_parity_err,
`endif
  output logic               o_tick
);

  localparam int CW = (NCYCLES_PER_TICK > 1) ? $clog2(NCYCLES_PER_TICK) : 1;
  localparam int BW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NCYCLES_PER_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NB_DATA - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

  // ---------------- tick generator ----------------
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;

  assign tick   = (cnt_q == CNT_LAST);
  assign cnt_d  = tick ? '0 : cnt_q + CW'(1);
  assign o_tick = tick;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // ---------------- transmitter ----------------
  state_e               tx_state_q, tx_state_d;
  logic [3:0]           tx_tcnt_q, tx_tcnt_d;
  logic [BW-1:0]        tx_bcnt_q, tx_bcnt_d;
  logic [NB_DATA-1:0]   tx_sh_q, tx_sh_d;
  logic                 tx_done_q, tx_done_d;
  logic                 tx_blast;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  assign tx_blast = tick && (tx_tcnt_q == 4'd15);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bcnt_d  = tx_bcnt_q;
    tx_sh_d    = tx_sh_q;
    tx_done_d  = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    // The 4-bit tick counter wraps 15->0 on its own, so every bit is 16 ticks.
    if (tx_state_q != S_IDLE && tick) tx_tcnt_d = tx_tcnt_q + 4'd1;
    case (tx_state_q)
      S_IDLE: if (i_tx_start) begin
        tx_sh_d    = i_tx_data;
        tx_tcnt_d  = '0;
        tx_bcnt_d  = '0;
`ifdef UART_PARITY_EN
        tx_par_d   = ^i_tx_data;
`endif
        tx_state_d = S_START;
      end
      S_START: if (tx_blast) tx_state_d = S_DATA;
      S_DATA: if (tx_blast) begin
        tx_sh_d   = tx_sh_q >> 1;
        tx_bcnt_d = tx_bcnt_q + BW'(1);
        if (tx_bcnt_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
          tx_state_d = S_PAR;
`else
          tx_state_d = S_STOP;
`endif
        end
      end
      S_PAR:  if (tx_blast) tx_state_d = S_STOP;
      S_STOP: if (tx_blast) begin
        tx_state_d = S_IDLE;
        tx_done_d  = 1'b1;
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_tx = 1'b1;
    case (tx_state_q)
      S_START: o_tx = 1'b0;
      S_DATA:  o_tx = tx_sh_q[0];
`ifdef UART_PARITY_EN
      S_PAR:   o_tx = tx_par_q;
`endif
      default: o_tx = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      tx_state_q <= S_IDLE;
      tx_tcnt_q  <= '0;
      tx_bcnt_q  <= '0;
      tx_sh_q    <= '0;
      tx_done_q  <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bcnt_q  <= tx_bcnt_d;
      tx_sh_q    <= tx_sh_d;
      tx_done_q  <= tx_done_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  assign o_tx_done = tx_done_q;

  // ---------------- receiver ----------------
  logic [1:0]           sync_q;
  logic                 rx_s;
  state_e               rx_state_q, rx_state_d;
  logic [3:0]           rx_tcnt_q, rx_tcnt_d;
  logic [BW-1:0]        rx_bcnt_q, rx_bcnt_d;
  logic [NB_DATA-1:0]   rx_sh_q, rx_sh_d;
  logic [NB_DATA-1:0]   rx_data_q, rx_data_d;
  logic                 rx_done_q, rx_done_d;
  logic                 rx_blast, rx_mid;
`ifdef UART_PARITY_EN
  logic                 rx_pbad_q, rx_pbad_d;
  logic                 rx_perr_q, rx_perr_d;
`endif

  assign rx_s     = sync_q[1];
  assign rx_blast = tick && (rx_tcnt_q == 4'd15);
  assign rx_mid   = tick && (rx_tcnt_q == 4'd7);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bcnt_d  = rx_bcnt_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_done_d  = 1'b0;
`ifdef UART_PARITY_EN
    rx_pbad_d  = rx_pbad_q;
    rx_perr_d  = 1'b0;
`endif
    if (rx_state_q != S_IDLE && tick) rx_tcnt_d = rx_tcnt_q + 4'd1;
    case (rx_state_q)
      S_IDLE: if (!rx_s) begin
        rx_tcnt_d  = '0;
        rx_state_d = S_START;
      end
      // Re-centre on the start bit so later samples land mid-bit.
      S_START: if (rx_mid) begin
        rx_tcnt_d  = '0;
        rx_bcnt_d  = '0;
        rx_state_d = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_blast) begin
        rx_sh_d   = {rx_s, rx_sh_q[NB_DATA-1:1]};
        rx_bcnt_d = rx_bcnt_q + BW'(1);
        if (rx_bcnt_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
          rx_state_d = S_PAR;
`else
          rx_state_d = S_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      S_PAR: if (rx_blast) begin
        rx_pbad_d  = rx_s ^ (^rx_sh_q);
        rx_state_d = S_STOP;
      end
`endif
      S_STOP: if (rx_blast) begin
        rx_state_d = S_IDLE;
        if (rx_s) begin
`ifdef UART_PARITY_EN
          if (rx_pbad_q) rx_perr_d = 1'b1;
          else begin
            rx_data_d = rx_sh_q;
            rx_done_d = 1'b1;
          end
`else
          rx_data_d = rx_sh_q;
          rx_done_d = 1'b1;
`endif
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync_q     <= 2'b11;
      rx_state_q <= S_IDLE;
      rx_tcnt_q  <= '0;
      rx_bcnt_q  <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_done_q  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_pbad_q  <= 1'b0;
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      sync_q     <= {sync_q[0], i_rx};
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bcnt_q  <= rx_bcnt_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_done_q  <= rx_done_d;
`ifdef UART_PARITY_EN
      rx_pbad_q  <= rx_pbad_d;
      rx_perr_q  <= rx_perr_d;
`endif
    end
  end

  assign o_rx_data = rx_data_q;
  assign o_rx_done = rx_done_q;
`ifdef UART_PARITY_EN
  assign o_rx_parity_err = rx_perr_q;
`endif

endmodule

// File: tb/tb_uart_core.sv
// Directed + random bench for uart_core: loopback, glitch and framing rejection, mid-frame reset.
module tb_uart_core;
  localparam int NB   = 8;
  localparam int N    = 5;
  localparam int BITC = 16 * N;
`ifdef UART_PARITY_EN
  localparam int NBITS = NB + 3;
`else
  localparam int NBITS = NB + 2;
`endif
  localparam int FRAME_CYC = NBITS * BITC + 4 * N + 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] tx_data = '0;
  logic          tx_start = 1'b0;
  logic          rx_drv = 1'b1;
  logic          lb = 1'b0;
  logic          o_tx, o_tx_done, o_rx_done, o_tick, rx_line;
  logic [NB-1:0] o_rx_data;
`ifdef UART_PARITY_EN
  logic          o_perr;
`endif

  int total = 0, bad = 0;
  int cyc = 0, txd_cnt = 0, rxd_cnt = 0, last_tick = -1, tmin = 1 << 30, tmax = 0;

  assign rx_line = lb ? o_tx : rx_drv;

  uart_core #(.NB_DATA(NB), .NCYCLES_PER_TICK(N)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_tx_data(tx_data), .i_tx_start(tx_start),
    .o_tx(o_tx), .o_tx_done(o_tx_done), .i_rx(rx_line), .o_rx_data(o_rx_data),
    .o_rx_done(o_rx_done),
`ifdef UART_PARITY_EN
    .o_rx_parity_err(o_perr),
`endif
    .o_tick(o_tick));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (o_tx_done) txd_cnt <= txd_cnt + 1;
    if (o_rx_done) rxd_cnt <= rxd_cnt + 1;
    if (o_tick) begin
      if (last_tick >= 0) begin
        if (cyc - last_tick < tmin) tmin <= cyc - last_tick;
        if (cyc - last_tick > tmax) tmax <= cyc - last_tick;
      end
      last_tick <= cyc;
    end
  end

  // Reference serial frame: bit j of the line waveform for byte b.
  function automatic logic fbit(input logic [NB-1:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= NB) return b[j-1];
`ifdef UART_PARITY_EN
    if (j == NB + 1) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_lb(input logic [NB-1:0] b, input bit poke);
    int  rx0;
    bit  seen;
    rx0 = rxd_cnt;
    @(negedge clk); tx_data = b; tx_start = 1'b1;
    @(negedge clk); tx_start = 1'b0; tx_data = NB'($urandom);
    seen = 1'b0;
    for (int c = 0; c < FRAME_CYC && !seen; c++) begin
      @(negedge clk);
      if (poke && c == 300) begin tx_start = 1'b1; tx_data = ~b; end
      else tx_start = 1'b0;
      if (o_tx_done) seen = 1'b1;
    end
    chk("lb_done", 32'(seen), 32'd1);
    chk("lb_data", 32'(o_rx_data), 32'(b));
    chk("lb_rx_before_tx", 32'(rxd_cnt), 32'(rx0 + 1));
  endtask

  task automatic drive_frame(input logic [NB-1:0] b, input bit good_stop);
    for (int j = 0; j < NBITS - 1; j++) begin
      rx_drv = fbit(b, j);
      repeat (BITC) @(negedge clk);
    end
    rx_drv = good_stop;
    repeat (good_stop ? BITC : 12 * N) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * BITC) @(negedge clk);
  endtask

  initial begin
    logic [NB-1:0] bytes [10];
    logic [NB-1:0] last_b;
    logic          prev_tx;
    bit            zero_seen, seen;
    int            ticks, r, f, txs, rxs;

    // reset values
    #1;
    chk("rst_tx", 32'(o_tx), 32'd1);
    chk("rst_tick", 32'(o_tick), 32'd0);
    chk("rst_tx_done", 32'(o_tx_done), 32'd0);
    chk("rst_rx_done", 32'(o_rx_done), 32'd0);
    chk("rst_rx_data", 32'(o_rx_data), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // idle: line stays high, no done pulses, tick period exact
    zero_seen = 1'b0;
    repeat (2000) begin @(negedge clk); if (!o_tx) zero_seen = 1'b1; end
    chk("idle_tx_low", 32'(zero_seen), 32'd0);
    chk("idle_tx_done", 32'(txd_cnt), 32'd0);
    chk("idle_rx_done", 32'(rxd_cnt), 32'd0);
    chk("tick_min", 32'(tmin), 32'(N));
    chk("tick_max", 32'(tmax), 32'(N));

    // A5 loopback, bit-by-bit waveform check
    lb = 1'b1;
    rxs = rxd_cnt;
    @(negedge clk); tx_data = 8'hA5; tx_start = 1'b1;
    @(negedge clk); tx_start = 1'b0; tx_data = 8'hFF;
    chk("a5_start_bit", 32'(o_tx), 32'd0);
    ticks = o_tick ? 1 : 0;
    prev_tx = 1'b0; r = -1; f = -1; seen = 1'b0;
    for (int c = 0; c < FRAME_CYC && !seen; c++) begin
      @(negedge clk);
      if (o_tx_done) seen = 1'b1;
      if (o_tx && !prev_tx && r < 0) r = c;
      else if (!o_tx && prev_tx && r >= 0 && f < 0) f = c;
      prev_tx = o_tx;
      if (o_tick) begin
        ticks++;
        if (ticks % 16 == 8 && ticks / 16 >= 1 && ticks / 16 < NBITS)
          chk($sformatf("a5_bit%0d", ticks / 16), 32'(o_tx), 32'(fbit(8'hA5, ticks / 16)));
      end
    end
    chk("a5_done", 32'(seen), 32'd1);
    chk("a5_bit_len", 32'(f - r), 32'(BITC));
    chk("a5_rx_data", 32'(o_rx_data), 32'hA5);
    chk("a5_rx_cnt", 32'(rxd_cnt), 32'(rxs + 1));

    // back-to-back random bytes, including the extremes
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    for (int i = 2; i < 10; i++) bytes[i] = NB'($urandom);
    for (int i = 0; i < 10; i++) send_lb(bytes[i], i == 0);
    last_b = bytes[9];

    // short low glitch on the line must be rejected
    lb = 1'b0;
    repeat (3 * BITC) @(negedge clk);
    rxs = rxd_cnt;
    rx_drv = 1'b0;
    repeat (3 * N) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * BITC) @(negedge clk);
    chk("glitch_no_done", 32'(rxd_cnt), 32'(rxs));
    chk("glitch_data_held", 32'(o_rx_data), 32'(last_b));

    // framing error: stop bit low, then a good frame
    drive_frame(8'h3C, 1'b0);
    chk("frame_err_no_done", 32'(rxd_cnt), 32'(rxs));
    chk("frame_err_data_held", 32'(o_rx_data), 32'(last_b));
    drive_frame(8'h11, 1'b1);
    chk("after_err_done", 32'(rxd_cnt), 32'(rxs + 1));
    chk("after_err_data", 32'(o_rx_data), 32'h11);

    // reset in the middle of the data bits
    lb = 1'b1;
    @(negedge clk); tx_data = 8'h5A; tx_start = 1'b1;
    @(negedge clk); tx_start = 1'b0;
    repeat (3 * BITC) @(negedge clk);
    txs = txd_cnt; rxs = rxd_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(o_tx), 32'd1);
    chk("mid_rst_tick", 32'(o_tick), 32'd0);
    chk("mid_rst_rx_data", 32'(o_rx_data), 32'd0);
    repeat (3) @(negedge clk);
    chk("mid_rst_hold_tx", 32'(o_tx), 32'd1);
    rst_n = 1'b1;
    repeat (FRAME_CYC) @(negedge clk);
    chk("mid_rst_no_tx_done", 32'(txd_cnt), 32'(txs));
    chk("mid_rst_no_rx_done", 32'(rxd_cnt), 32'(rxs));
    send_lb(8'hC3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
